// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg
// Shared constants for the round-robin RAM controller: FSM state encoding
// and the default RAM geometry (16 x 8).
package ram_ctrl_pkg;

    // FSM state encoding
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CMD     = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    // Default RAM geometry
    localparam int DEFAULT_ADDR_W = 4;
    localparam int DEFAULT_DATA_W = 8;

endpackage : ram_ctrl_pkg

// File: rtl/ram_rr_controller_arbiter.sv
// rr_arbiter
// Purely combinational round-robin picker. The winner is the first set bit
// of req found when scanning upward from ptr+1, wrapping modulo N.
// Ports:
//   req    in  N           request vector
//   ptr    in  $clog2(N)   index of the previous winner
//   winner out N           one-hot winner (all zero when req == 0)
//   index  out $clog2(N)   binary index of the winner (0 when req == 0)
//   any    out 1           at least one request is present
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         winner,
    output logic [$clog2(N)-1:0] index,
    output logic                 any
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0]   shamt;
    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_rot_dbl;
    logic [N-1:0]     req_rot;
    logic [N-1:0]     pick_rot;
    logic [2*N-1:0]   pick_dbl;

    // Rotate so that position ptr+1 lands on bit 0. shamt can reach N, which
    // is why it carries one extra bit; the doubled vector keeps the wrap exact.
    assign shamt       = {1'b0, ptr} + (IDX_W + 1)'(1);
    assign req_dbl     = {req, req};
    assign req_rot_dbl = req_dbl >> shamt;
    assign req_rot     = req_rot_dbl[N-1:0];

    // Isolate the lowest set bit (x & -x), then rotate back into place.
    assign pick_rot = req_rot & (~req_rot + N'(1));
    assign pick_dbl = {pick_rot, pick_rot} << shamt;
    assign winner   = pick_dbl[2*N-1:N];

    assign any = |req;

    // One-hot to binary: index bit b is the OR of all winner bits whose
    // position has bit b set.
    genvar gi, gb;
    generate
        for (gb = 0; gb < IDX_W; gb++) begin : g_idx_bit
            logic [N-1:0] hit;
            for (gi = 0; gi < N; gi++) begin : g_pos
                if (((gi >> gb) & 1) != 0) begin : g_set
                    assign hit[gi] = winner[gi];
                end else begin : g_clr
                    assign hit[gi] = 1'b0;
                end
            end
            assign index[gb] = |hit;
        end
    endgenerate

endmodule : rr_arbiter

// File: rtl/ram_rr_controller.sv
// ram_rr_controller
// Shares one dual-port RAM (registered read) among NUM_REQ requesters.
// A request is sampled in IDLE, granted in the following CMD cycle, and for
// reads the RAM output is captured in RD_WAIT and presented one cycle later
// with a one-hot rvalid pulse.
// Ports:
//   clk          in   system clock (also drives the RAM's wr_clk / rd_clk)
//   rst          in   asynchronous active-high reset
//   req/we       in   per-requester request and command type (1 = write)
//   addr/wdata   in   packed per-requester address / write data
//   gnt          out  one-hot acceptance pulse (CMD cycle)
//   rvalid       out  one-hot read-data-valid pulse
//   rdata        out  read data, held until the next read completes
//   busy         out  controller not in IDLE
//   ram_wr_*     out  RAM write port
//   ram_rd_*     out  RAM read port request
//   ram_rd_data  in   RAM registered read data
module ram_rr_controller
    import ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic                      ram_wr_en,
    output logic [ADDR_W-1:0]         ram_wr_addr,
    output logic [DATA_W-1:0]         ram_wr_data,
    output logic                      ram_rd_en,
    output logic [ADDR_W-1:0]         ram_rd_addr,
    input  logic [DATA_W-1:0]         ram_rd_data
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [1:0]         state_reg;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               we_lat_reg;
    logic [ADDR_W-1:0]  addr_lat_reg;
    logic [DATA_W-1:0]  wdata_lat_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [NUM_REQ-1:0] rvalid_reg;

    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_index;
    logic               arb_any;
    logic [NUM_REQ-1:0] idx_onehot;

    logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]   = addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi]  = wdata[gi*DATA_W +: DATA_W];
            assign idx_onehot[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arbiter (
        .req    (req),
        .ptr    (rr_ptr_reg),
        .winner (arb_winner),
        .index  (arb_index),
        .any    (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= IDX_W'(NUM_REQ - 1);
            idx_reg       <= '0;
            we_lat_reg    <= 1'b0;
            addr_lat_reg  <= '0;
            wdata_lat_reg <= '0;
            rdata_reg     <= '0;
            rvalid_reg    <= '0;
        end else begin
            rvalid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    // req is only looked at here; the latch frees the
                    // requester to change its inputs once gnt is seen.
                    if (arb_any) begin
                        idx_reg       <= arb_index;
                        we_lat_reg    <= |(we & arb_winner);
                        addr_lat_reg  <= addr_arr[arb_index];
                        wdata_lat_reg <= wdata_arr[arb_index];
                        rr_ptr_reg    <= arb_index;
                        state_reg     <= CMD;
                    end
                end
                CMD: begin
                    state_reg <= we_lat_reg ? IDLE : RD_WAIT;
                end
                RD_WAIT: begin
                    // RAM output corresponds to the address issued in CMD.
                    rdata_reg  <= ram_rd_data;
                    rvalid_reg <= idx_onehot;
                    state_reg  <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Everything below is decoded from registers only, so there is no
    // combinational path from req to gnt or to the RAM enables.
    assign gnt         = (state_reg == CMD) ? idx_onehot : '0;
    assign ram_wr_en   = (state_reg == CMD) &&  we_lat_reg;
    assign ram_rd_en   = (state_reg == CMD) && !we_lat_reg;
    assign ram_wr_addr = addr_lat_reg;
    assign ram_wr_data = wdata_lat_reg;
    assign ram_rd_addr = addr_lat_reg;
    assign rvalid      = rvalid_reg;
    assign rdata       = rdata_reg;
    assign busy        = (state_reg != IDLE);

endmodule : ram_rr_controller

// File: tb/tb_ram_rr_controller.sv
// tb_ram_rr_controller
// Directed + randomized bench. A behavioural model tracks pending requests,
// round-robin order, controller availability and a shadow copy of the RAM.
module tb_ram_rr_controller;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic            ram_wr_en;
    logic [AW-1:0]   ram_wr_addr;
    logic [DW-1:0]   ram_wr_data;
    logic            ram_rd_en;
    logic [AW-1:0]   ram_rd_addr;
    logic [DW-1:0]   ram_rd_data = '0;

    always #5 clk = ~clk;

    ram_rr_controller #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // 16x8 dual-port RAM with registered read; its own reset is tied low.
    logic [DW-1:0] ram_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_en) ram_rd_data <= ram_mem[ram_rd_addr];
    end

    // ---------------- reference model state ----------------
    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int next_idle = 0;   // first cycle in which the controller is IDLE again
    int mptr = N - 1;

    bit            pend    [N];
    logic          p_we    [N];
    logic [AW-1:0] p_addr  [N];
    logic [DW-1:0] p_wdata [N];
    int            re_cnt  [N];
    logic          prev_we    [N];
    logic [AW-1:0] prev_addr  [N];
    logic [DW-1:0] prev_wdata [N];
    logic [N-1:0]  req_prev = '0;
    bit            auto_re = 1'b0;
    bit            rand_mode = 1'b0;

    logic [DW-1:0] shadow [16] = '{default: '0};
    logic [DW-1:0] last_rd = '0;

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        int            due;
    } rd_exp_t;
    rd_exp_t rdq[$];
    int      glog[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit model_quiet();
        bit q;
        q = (rdq.size() == 0) && (cyc >= next_idle) && (req_prev == '0);
        for (int i = 0; i < N; i++) if (pend[i] || re_cnt[i] != 0) q = 1'b0;
        return q;
    endfunction

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i] = 1'b1; p_we[i] = w; p_addr[i] = a; p_wdata[i] = d;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i] = pend[i];
            we[i]  = p_we[i];
            addr[i*AW +: AW]  = p_addr[i];
            wdata[i*DW +: DW] = p_wdata[i];
            prev_we[i] = p_we[i]; prev_addr[i] = p_addr[i]; prev_wdata[i] = p_wdata[i];
        end
        req_prev = req;
    endtask

    // One clock cycle: check outputs against the model, then drive new inputs.
    task automatic step();
        logic [N-1:0] exp_gnt;
        logic         exp_busy;
        int           w;
        rd_exp_t      e;
        @(negedge clk);
        cyc++;
        exp_gnt = '0;
        w = -1;
        if (cyc - 1 >= next_idle && req_prev != '0) begin
            w = rr_pick(mptr, req_prev);
            exp_gnt[w] = 1'b1;
        end
        exp_busy = (w >= 0) || (cyc < next_idle);
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("single_en", 32'(ram_wr_en & ram_rd_en), 32'(0));
        if (w >= 0) begin
            chk("wr_en", 32'(ram_wr_en), 32'(prev_we[w]));
            chk("rd_en", 32'(ram_rd_en), 32'(!prev_we[w]));
            if (prev_we[w]) begin
                chk("wr_addr", 32'(ram_wr_addr), 32'(prev_addr[w]));
                chk("wr_data", 32'(ram_wr_data), 32'(prev_wdata[w]));
                shadow[prev_addr[w]] = prev_wdata[w];
                next_idle = cyc + 1;
                $display("[cyc %0d] grant req%0d WRITE addr=%h data=%h", cyc, w, prev_addr[w], prev_wdata[w]);
            end else begin
                chk("rd_addr", 32'(ram_rd_addr), 32'(prev_addr[w]));
                e.who = w; e.data = shadow[prev_addr[w]]; e.due = cyc + 2;
                rdq.push_back(e);
                next_idle = cyc + 2;
                $display("[cyc %0d] grant req%0d READ  addr=%h", cyc, w, prev_addr[w]);
            end
            mptr = w;
            pend[w] = 1'b0;
            glog.push_back(w);
            if (auto_re) re_cnt[w] = 2;
        end else begin
            chk("no_en", 32'({ram_wr_en, ram_rd_en}), 32'(0));
        end
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            chk("rvalid", 32'(rvalid), 32'(1) << rdq[0].who);
            chk("rdata", 32'(rdata), 32'(rdq[0].data));
            last_rd = rdq[0].data;
            $display("[cyc %0d] rvalid req%0d data=%h", cyc, rdq[0].who, rdata);
            void'(rdq.pop_front());
        end else begin
            chk("rvalid_idle", 32'(rvalid), 32'(0));
            chk("rdata_hold", 32'(rdata), 32'(last_rd));
        end
        // reassertion one cycle after the gnt cycle
        for (int i = 0; i < N; i++) begin
            if (re_cnt[i] > 0) begin
                re_cnt[i]--;
                if (re_cnt[i] == 0) pend[i] = 1'b1;
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
                else if (pend[i] && $urandom_range(0, 15) == 0)
                    pend[i] = 1'b0;   // withdraw before gnt
            end
        end
        drive_inputs();
    endtask

    task automatic drain(input string tag, input int bound);
        for (int s = 0; s < bound && !model_quiet(); s++) step();
        chk({"drain_", tag}, 32'(model_quiet()), 32'(1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; re_cnt[i] = 0; end
        drive_inputs();
        #1;
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_rvalid", 32'(rvalid), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_rdata", 32'(rdata), 32'(0));
        chk("rst_en", 32'({ram_wr_en, ram_rd_en}), 32'(0));
        chk("rst_addr", 32'({ram_wr_addr, ram_rd_addr, ram_wr_data}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        mptr = N - 1;
        rdq.delete();
        last_rd = '0;
        next_idle = cyc;
        req_prev = '0;
    endtask

    int exp_order[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; p_we[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; re_cnt[i] = 0;
        end
        #2;
        do_reset();

        // First arbitration after reset with all four requesting
        glog.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i), DW'($urandom_range(0, 255)));
        drive_inputs();
        drain("first", 40);
        chk("first_cnt", 32'(glog.size()), 32'(4));
        chk("first_winner", 32'(glog[0]), 32'(0));

        // Write then read of the same address from different requesters
        set_req(1, 1'b1, 4'hA, 8'h5C);
        drive_inputs();
        drain("wr_a", 20);
        set_req(2, 1'b0, 4'hA, 8'h00);
        drive_inputs();
        drain("rd_a", 20);
        chk("rd_a_data", 32'(rdata), 32'(8'h5C));

        // Fairness: park the pointer at 3, then everyone requests with reassert
        set_req(3, 1'b1, 4'h3, 8'h33);
        drive_inputs();
        drain("park3", 20);
        glog.delete();
        auto_re = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 4), DW'($urandom_range(0, 255)));
        drive_inputs();
        for (int s = 0; s < 60 && glog.size() < 6; s++) step();
        auto_re = 1'b0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; re_cnt[i] = 0; end
        drive_inputs();
        drain("fair", 20);
        chk("fair_cnt", 32'(glog.size() >= 6), 32'(1));
        for (int i = 0; i < 6; i++) chk($sformatf("fair_order%0d", i), 32'(glog[i]), 32'(exp_order[i]));

        // Pointer wrap: last grant 2, then req = 4'b1001
        set_req(2, 1'b1, 4'h2, 8'h22);
        drive_inputs();
        drain("last2", 20);
        glog.delete();
        set_req(0, 1'b1, 4'h0, 8'h10);
        set_req(3, 1'b1, 4'h1, 8'h31);
        drive_inputs();
        drain("wrap", 20);
        chk("wrap_cnt", 32'(glog.size()), 32'(2));
        chk("wrap_first", 32'(glog[0]), 32'(3));
        chk("wrap_second", 32'(glog[1]), 32'(0));

        // Boundary address, back-to-back reads
        set_req(0, 1'b1, 4'hF, 8'hFF);
        drive_inputs();
        drain("wr_f", 20);
        set_req(1, 1'b0, 4'h0, 8'h00);
        set_req(2, 1'b0, 4'hF, 8'h00);
        drive_inputs();
        drain("rd_0f", 30);
        chk("rd_f_data", 32'(rdata), 32'(8'hFF));

        // Randomized traffic
        rand_mode = 1'b1;
        repeat (300) step();
        rand_mode = 1'b0;
        drain("rand", 60);

        // Reset while a read from requester 3 sits in RD_WAIT
        glog.delete();
        set_req(3, 1'b0, AW'($urandom_range(0, 15)), 8'h00);
        drive_inputs();
        for (int s = 0; s < 10 && rdq.size() == 0; s++) step();
        chk("rdwait_granted", 32'(rdq.size()), 32'(1));
        step();   // RD_WAIT cycle
        do_reset();
        repeat (4) step();
        glog.delete();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 8), DW'($urandom_range(0, 255)));
        drive_inputs();
        drain("post_rst", 40);
        chk("post_rst_first", 32'(glog[0]), 32'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_ram_rr_controller

// File: doc/ram_rr_controller.md
Name: ram_rr_controller

Overview:
- Single-clock round-robin arbiter and sequencer that shares one 16x8 dual-port RAM among NUM_REQ requesters.
- Requesters issue read or write commands over a req/gnt handshake.
- The controller drives the RAM's write and read ports (wr_clk and rd_clk both tied to clk at the top level) and returns read data with a per-requester valid pulse.
- Sits between client engines and the RAM instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 4, RAM address width (16 locations).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  single system clock; RAM wr_clk/rd_clk are driven from the same net.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester request.
- we  in  NUM_REQ  per-requester command type: 1 = write, 0 = read.
- addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
- gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse.
- rdata  out  DATA_W  read data; meaningful only while any rvalid bit is high.
- busy  out  1  high while state != IDLE.
- ram_wr_en  out  1  RAM write enable.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_wr_data  out  DATA_W  RAM write data.
- ram_rd_en  out  1  RAM read enable.
- ram_rd_addr  out  ADDR_W  RAM read address.
- ram_rd_data  in  DATA_W  RAM registered read output.

Behaviour:
- Reset: state = IDLE; rr_ptr = NUM_REQ-1, so requester 0 has highest priority first.
  - All outputs are 0.
  - All latched command registers are cleared.
  - The RAM's own rst is tied low by the integrator.
- FSM states: IDLE, CMD, RD_WAIT.
- IDLE:
  - If req != 0, select the winner by round-robin: first set bit scanning from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - Latch the winner's index, we, addr and wdata; set rr_ptr = winner; go to CMD.
  - If req == 0, stay in IDLE.
  - req is sampled only in IDLE.
- CMD (exactly 1 cycle):
  - gnt[idx] = 1.
  - Write: ram_wr_en = 1, ram_wr_addr and ram_wr_data from the latch; next state is IDLE.
  - Read: ram_rd_en = 1, ram_rd_addr from the latch; next state is RD_WAIT.
  - Only one of ram_wr_en / ram_rd_en is ever high.
- RD_WAIT (1 cycle):
  - ram_rd_data is valid this cycle.
  - Register it into rdata and set rvalid[idx] for the next cycle; go to IDLE.
- Timing, with T0 = IDLE cycle where req is sampled:
  - gnt in T1.
  - Write lands in the RAM at the T1 edge.
  - rvalid and rdata in T3.
  - rdata holds its value until the next read completes.
- Throughput:
  - Write: one transaction per 2 cycles.
  - Read: one transaction per 3 cycles.
  - The IDLE cycle in which rvalid is high may already arbitrate the next request.
- Requester rules:
  - Hold req, we, addr and wdata stable until gnt is seen.
  - Deassert req in the gnt cycle; a req still high at the next IDLE counts as a new request.
  - Dropping req before gnt withdraws the request with no side effects.
- Ordering: write and read to the same address from different requesters are serialised in grant order; a read granted after a write returns the new data.
- Addresses wrap naturally; 4'hF is a legal address, and there is no out-of-range case.
- Reset mid-operation:
  - Asynchronous return to IDLE.
  - Pending gnt, RAM enables and rvalid are dropped immediately.
  - A write whose CMD cycle was interrupted before the edge is lost.
- gnt, rvalid, ram_* enables and busy are registered or decoded directly from state; no combinational path from req to gnt.

Decomposition:
- Package ram_ctrl_pkg holds:
  - State encoding constants: IDLE=2'd0, CMD=2'd1, RD_WAIT=2'd2.
  - Default ADDR_W/DATA_W constants.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req, ptr.
  - Outputs: one-hot winner, binary index, any.
  - Purely combinational.
  - Instantiated once.
- FSM, latches and RAM drive stay in ram_rr_controller.

Test Plan:
- Reset check -> all outputs 0 and busy = 0; then a first request from requester 0 while req = 4'b1111 -> gnt = 4'b0001.
- Write-then-read: requester 1 writes addr 4'hA data 8'h5C, then requester 2 reads 4'hA -> gnt 1 cycle after sampling; ram_wr_en for 1 cycle with addr A / data 5C; read gives rvalid = 4'b0100 and rdata = 8'h5C exactly 2 cycles after its gnt.
- Fairness: req = 4'b1111 held, each requester dropping req on gnt and reasserting 1 cycle later -> grant order 0,1,2,3,0,1 with no requester granted twice in a row while others wait.
- Pointer wrap: last grant = 2, then req = 4'b1001 -> grant 3, then 0.
- Boundary address and back-to-back: write 8'hFF to 4'hF, then read 4'h0 and 4'hF -> rdata 8'hFF for the 4'hF read; exactly one RAM enable per CMD cycle throughout.
- Reset during RD_WAIT of a read from requester 3 -> no rvalid pulse, state IDLE, rr_ptr = NUM_REQ-1; the next request proceeds normally.
